dbc_portsc_change_tracker: RTL
==============================

DBC_PORTSC_CHANGE_TRACKER -- requirements
Module: dbc_portsc_change_tracker

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 8, meaning the number of consecutive mismatching samples needed to accept a connect change (legal range 2..255).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port DCE, input, 1, DbC enable.
REQ-005 SHALL have port ccs_raw, input, 1, raw connect status from the PHY.
REQ-006 SHALL have port link_state, input, 4, raw port link state.
REQ-007 SHALL have port port_reset_active, input, 1, high while bus reset is in progress.
REQ-008 SHALL have port config_error, input, 1, single-cycle configuration error pulse.
REQ-009 SHALL have port sw_clear, input, 4, software write-1-to-clear strobe in bit order {CEC,PRC,PLC,CSC}.
REQ-010 SHALL have outputs CCS, PED, PR, each output 1 bit, giving debounced connect status, port enabled and registered port reset.
REQ-011 SHALL have output PLS, 4 bits, the registered link state.
REQ-012 SHALL have outputs CSC, PLC, PRC, CEC, each output 1 bit, the sticky change bits consumed by the downstream DbC port state machine.
REQ-013 SHALL have output change_irq, 1 bit, a one-cycle event pulse.

Function
REQ-014 SHALL, while DCE=0, hold all outputs, the debounce counter and the history registers at their reset values; the block ignores all other inputs.
REQ-015 SHALL keep an 8-bit debounce counter: increment each edge ccs_raw!=CCS, clear to 0 on any edge ccs_raw==CCS.
REQ-016 SHALL, on the edge where the counter equals DEBOUNCE_CYCLES-1 and ccs_raw!=CCS, load CCS<=ccs_raw, set CSC, and clear the counter; CCS thus changes on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
REQ-017 SHALL discard a glitch shorter than DEBOUNCE_CYCLES edges (counter returns to 0 and CCS/CSC do not change).
REQ-018 SHALL register link_state into PLS every edge (1-cycle latency), and set PLC when link_state!=PLS and CCS=1.
REQ-019 SHALL register port_reset_active into PR every edge, and set PRC on the edge where PR=1 and port_reset_active=0 (falling edge).
REQ-020 SHALL set PED on that same reset-completion edge if CCS=1.
REQ-021 SHALL clear PED on the edge where debounced CCS goes 1->0, or on any edge with config_error=1.
REQ-022 SHALL set CEC on an edge with config_error=1 and CCS=1.
REQ-023 SHALL clear each change bit at the next edge when its sw_clear bit is 1; a set event on the same edge wins over the clear.
REQ-024 SHALL leave change bits unaffected by sw_clear bits that are 0, and by sw_clear when the bit is already 0.
REQ-025 SHALL pulse change_irq high for exactly the one cycle following any edge on which at least one change bit goes 0->1; simultaneous sets yield a single pulse.
REQ-026 SHALL NOT pulse change_irq for a set event on an already-set bit.
REQ-027 SHALL, when debounced disconnect and reset completion coincide, set CSC and PRC and leave PED=0.

Reset
REQ-028 SHALL, on any edge with reset=1, drive CCS, PED, PR, PLS=4'h0, CSC, PLC, PRC, CEC and change_irq to 0, and clear the counter and history; reset dominates DCE and all other inputs.
REQ-029 SHALL, when reset is asserted mid-debounce, discard the partial count so that a new debounce starts from 0 after release.

Verification
REQ-030 SHALL be covered by this scenario: ccs_raw 0->1 held, DCE=1, DEBOUNCE_CYCLES=8 -> CCS=1 and CSC=1 on the 8th edge, change_irq=1 for the following cycle only.
REQ-031 SHALL be covered by this scenario: ccs_raw high for 5 edges then low -> CCS, CSC and change_irq stay 0.
REQ-032 SHALL be covered by this scenario: with CCS=1, port_reset_active 1 for 10 cycles then 0 -> PRC=1 and PED=1 on the falling-edge sample; a later config_error pulse -> PED=0, CEC=1.
REQ-033 SHALL be covered by this scenario: link_state 4'h0->4'h5 with CCS=1 -> PLS=4'h5 next edge, PLC=1; sw_clear=4'b0010 on the edge of a new change -> PLC stays 1.
REQ-034 SHALL be covered by this scenario: sw_clear=4'b1111 with all change bits set -> all cleared next edge, CCS/PED/PLS unchanged.
REQ-035 SHALL be covered by this scenario: reset=1 at counter=6 mid-debounce, then released -> all outputs 0 and 8 fresh mismatching edges are required for CCS=1; DCE=0 -> outputs held at 0.

Source files
------------

// File: rtl/dbc_portsc_change_tracker_if.sv
// Status/strobe bundle between the DbC PORTSC change tracker and its environment.
// The tracker uses the slave view; whoever drives the PHY-side inputs uses the master view.
interface dbc_portsc_change_tracker_if;
  logic       DCE;
  logic       ccs_raw;
  logic [3:0] link_state;
  logic       port_reset_active;
  logic       config_error;
  logic [3:0] sw_clear;
  logic       CCS;
  logic       PED;
  logic       PR;
  logic [3:0] PLS;
  logic       CSC;
  logic       PLC;
  logic       PRC;
  logic       CEC;
  logic       change_irq;

  modport master (
    output DCE, ccs_raw, link_state, port_reset_active, config_error, sw_clear,
    input  CCS, PED, PR, PLS, CSC, PLC, PRC, CEC, change_irq
  );

  modport slave (
    input  DCE, ccs_raw, link_state, port_reset_active, config_error, sw_clear,
    output CCS, PED, PR, PLS, CSC, PLC, PRC, CEC, change_irq
  );
endinterface

// File: rtl/dbc_portsc_change_tracker.sv
// DbC PORTSC status tracker: debounces connect status, registers link/reset state
// and maintains the sticky W1C change bits plus a one-cycle change interrupt.
module dbc_portsc_change_tracker #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  dbc_portsc_change_tracker_if.slave    p
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       ccs_q, ccs_d;
  logic       ped_q, ped_d;
  logic       pr_q, pr_d;
  logic [3:0] pls_q, pls_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] chg_q, chg_d;   // {CEC,PRC,PLC,CSC}
  logic       irq_q, irq_d;
  logic [3:0] set_ev;
  logic       ccs_fall;
  logic       rst_done;

  always_comb begin
    ccs_d    = 1'b0;
    ped_d    = 1'b0;
    pr_d     = 1'b0;
    pls_d    = 4'h0;
    cnt_d    = 8'd0;
    irq_d    = 1'b0;
    set_ev   = 4'b0000;
    ccs_fall = 1'b0;
    rst_done = 1'b0;
    if (p.DCE) begin
      ccs_d = ccs_q;
      ped_d = ped_q;
      if (p.ccs_raw != ccs_q) begin
        if (cnt_q == CNT_LAST) begin
          ccs_d     = p.ccs_raw;
          set_ev[0] = 1'b1;
          ccs_fall  = ccs_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      rst_done  = pr_q & ~p.port_reset_active;
      set_ev[1] = (p.link_state != pls_q) & ccs_q;
      set_ev[2] = rst_done;
      set_ev[3] = p.config_error & ccs_q;
      pls_d     = p.link_state;
      pr_d      = p.port_reset_active;
      // A disconnect or config error must win over a coincident reset completion.
      if (ccs_fall || p.config_error) begin
        ped_d = 1'b0;
      end else if (rst_done && ccs_q) begin
        ped_d = 1'b1;
      end
      irq_d = |(set_ev & ~chg_q);
    end
  end

  // Each sticky bit: a set event beats a same-edge software clear.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chg
      assign chg_d[gi] = p.DCE & (set_ev[gi] | (chg_q[gi] & ~p.sw_clear[gi]));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      ccs_q <= 1'b0;
      ped_q <= 1'b0;
      pr_q  <= 1'b0;
      pls_q <= 4'h0;
      cnt_q <= 8'd0;
      chg_q <= 4'b0000;
      irq_q <= 1'b0;
    end else begin
      ccs_q <= ccs_d;
      ped_q <= ped_d;
      pr_q  <= pr_d;
      pls_q <= pls_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
      irq_q <= irq_d;
    end
  end

  assign p.CCS        = ccs_q;
  assign p.PED        = ped_q;
  assign p.PR         = pr_q;
  assign p.PLS        = pls_q;
  assign p.CSC        = chg_q[0];
  assign p.PLC        = chg_q[1];
  assign p.PRC        = chg_q[2];
  assign p.CEC        = chg_q[3];
  assign p.change_irq = irq_q;

endmodule
